// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module  : bus_master_if
//  Brief   : Core request/ack and multiplexed address/data pin bundle.
//  Revision: 1.0 - initial release
// ============================================================================
interface bus_master_if;
   logic        req;
   logic        wr;
   logic [19:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic [15:0] rdata;
   logic        busy;
   logic [19:0] ad_o;
   logic        ad_oe;
   logic [15:0] ad_i;
   logic        ale;
   logic        oe;
   logic        we;
   logic        pio;

   modport master (
      input  req, wr, addr, wdata, ad_i,
      output ack, rdata, busy, ad_o, ad_oe, ale, oe, we, pio
   );

   modport slave (
      output req, wr, addr, wdata, ad_i,
      input  ack, rdata, busy, ad_o, ad_oe, ale, oe, we, pio
   );
endinterface
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
//  Module  : bus_master
//  Brief   : Turns one core request into an ADDR/HOLD/DATA/END cycle on the
//            20-pin multiplexed address/data bus; acks with read data.
//  Revision: 1.0 - initial release
// ============================================================================
module bus_master #(
   parameter int WAIT_STATES = 1,
   parameter int TURNAROUND  = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   bus_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_HOLD = 3'd2,
      S_DATA = 3'd3,
      S_END  = 3'd4
   } state_t;

   localparam logic [2:0] c_wait    = 3'(WAIT_STATES);
   localparam logic [2:0] c_turn_m1 = 3'(TURNAROUND - 1);

   state_t      r_state;
   logic        r_wr;
   logic [15:0] r_wdata;
   logic [2:0]  r_cnt;
   logic        r_ack;
   logic [15:0] r_rdata;
   logic        r_busy;
   logic [19:0] r_ad_o;
   logic        r_ad_oe;
   logic        r_ale;
   logic        r_oe;
   logic        r_we;
   logic        r_pio;

   // Every bus output is registered: each state's strobe values are loaded
   // on the edge that enters it, so no pin can glitch within a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_wdata <= 16'h0000;
         r_cnt   <= 3'd0;
         r_ack   <= 1'b0;
         r_rdata <= 16'h0000;
         r_busy  <= 1'b0;
         r_ad_o  <= 20'h00000;
         r_ad_oe <= 1'b0;
         r_ale   <= 1'b0;
         r_oe    <= 1'b1;
         r_we    <= 1'b1;
         r_pio   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_wr    <= bus.wr;
                  r_wdata <= bus.wdata;
                  r_ad_o  <= {bus.addr[15:0], bus.addr[19:16]};
                  r_ad_oe <= 1'b1;
                  r_ale   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_ADDR;
               end
            end
            S_ADDR: begin
               r_ale   <= 1'b0;
               r_pio   <= 1'b1;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               r_oe    <= 1'b0;
               r_cnt   <= c_wait;
               r_state <= S_DATA;
               if (r_wr) begin
                  r_we         <= 1'b0;
                  r_ad_o[19:4] <= r_wdata;
               end else begin
                  r_ad_oe <= 1'b0;
               end
            end
            S_DATA: begin
               if (r_cnt == 3'd0) begin
                  // we and oe rise together; ad_o keeps wdata through this edge
                  r_oe    <= 1'b1;
                  r_we    <= 1'b1;
                  r_pio   <= 1'b0;
                  r_ad_oe <= 1'b0;
                  r_ack   <= 1'b1;
                  r_cnt   <= c_turn_m1;
                  r_state <= S_END;
                  if (!r_wr) begin
                     r_rdata <= bus.ad_i;
                  end
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_END: begin
               if (r_cnt == 3'd0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack   = r_ack;
   assign bus.rdata = r_rdata;
   assign bus.busy  = r_busy;
   assign bus.ad_o  = r_ad_o;
   assign bus.ad_oe = r_ad_oe;
   assign bus.ale   = r_ale;
   assign bus.oe    = r_oe;
   assign bus.we    = r_we;
   assign bus.pio   = r_pio;

endmodule
`default_nettype wire
